// File: rtl/ysyx_23060203_ifu_fetch_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060203_ifu_fetch_pkg
//   Shared definitions for the instruction fetch unit:
//     - OP_BRANCH : inst[6:2] value of RV32 conditional branches
//     - RESP_OKAY : read response code for a successful fetch
//     - fetch_state_e : fetch FSM states
//         REQ  : address phase, arvalid raised
//         WAIT : data phase, rready raised
//         HOLD : instruction presented to the IDU
// ---------------------------------------------------------------------------
package ysyx_23060203_ifu_fetch_pkg;

    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ysyx_23060203_ifu_fetch_bpu.sv
// ---------------------------------------------------------------------------
// ysyx_23060203_BPU
//   Static branch predictor, purely combinational.
//   A conditional branch with a negative offset (inst[31]=1) is predicted
//   taken; everything else (JAL, JALR, forward branches, other opcodes)
//   falls through to pc+4 and is left to the IDU to redirect.
//   Ports:
//     pc   in  32  PC of the instruction
//     inst in  32  instruction word
//     npc  out 32  predicted next PC (wraps mod 2^32)
// ---------------------------------------------------------------------------
module ysyx_23060203_BPU
    import ysyx_23060203_ifu_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    output logic [31:0] npc
);

    logic [31:0] imm_b;
    logic        taken;
    logic        unused_inst;

    assign imm_b = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    assign taken = (inst[6:2] == OP_BRANCH) && inst[31];
    assign npc   = taken ? pc + imm_b : pc + 32'd4;

    // Register fields and the low opcode bits play no part in the prediction.
    assign unused_inst = ^{inst[24:12], inst[1:0]};

endmodule

// File: rtl/ysyx_23060203_ifu_fetch.sv
// ---------------------------------------------------------------------------
// ysyx_23060203_ifu_fetch
//   Instruction fetch unit: holds the PC, fetches one instruction at a time
//   over an AXI4-Lite-style read channel and hands it to the IDU.
//
//   Handshakes: every channel (AR, R, IFU->IDU) transfers on a cycle where
//   valid and ready are both high at the clock edge; valid is never
//   withdrawn before the transfer and its payload stays stable meanwhile.
//   The one exception is out_valid, which is masked combinationally by a
//   redirect so a wrong-path instruction can never transfer in that cycle.
//
//   Ports:
//     clock, reset          clock, synchronous active-high reset
//     araddr/arvalid/arready            read address channel
//     rdata/rresp/rvalid/rready         read data channel
//     flush/flush_pc        EXU redirect (highest priority)
//     jump_flush/jump_dnpc  IDU misprediction redirect
//     out_valid/out_ready/out_pc/out_inst  instruction to the IDU
//     out_fault             response error flag (only with
//                           YSYX_23060203_IFU_FAULT_EN defined)
//     dbg_state             current FSM state (fetch_state_e encoding)
//
//   Optional feature macro: YSYX_23060203_IFU_FAULT_EN
// ---------------------------------------------------------------------------
module ysyx_23060203_ifu_fetch
    import ysyx_23060203_ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        jump_flush,
    input  logic [31:0] jump_dnpc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
`ifdef YSYX_23060203_IFU_FAULT_EN
    output logic        out_fault,
`endif
    output logic [1:0]  dbg_state
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         drop_q, drop_d;
    logic [31:0]  ar_addr_q, ar_addr_d;
    logic         started_q;
    logic [31:0]  out_pc_q, out_inst_q;
    logic         load_out;

    logic         redirect;
    logic [31:0]  tgt;
    logic         ar_fire;
    logic         r_fire;
    logic [31:0]  bpu_npc;
    logic [31:0]  npc;

    // Predicted successor of the held instruction.
    ysyx_23060203_BPU u_bpu (
        .pc   (pc_q),
        .inst (out_inst_q),
        .npc  (bpu_npc)
    );

`ifdef YSYX_23060203_IFU_FAULT_EN
    logic fault_q;
    // A faulted fetch carries garbage; never predict from it.
    assign npc       = fault_q ? pc_q + 32'd4 : bpu_npc;
    assign out_fault = fault_q;
`else
    logic unused_rresp;
    assign npc          = bpu_npc;
    assign unused_rresp = (rresp != RESP_OKAY);
`endif

    assign redirect = flush | jump_flush;
    assign tgt      = (flush ? flush_pc : jump_dnpc) & ~32'h1;

    // started_q keeps arvalid low while in reset and during the first
    // cycle after it, so the first request issues one cycle after release.
    assign arvalid   = (state_q == REQ) & started_q;
    assign araddr    = ar_addr_q;
    assign rready    = (state_q == WAIT);
    assign out_valid = (state_q == HOLD) & ~redirect;
    assign out_pc    = out_pc_q;
    assign out_inst  = out_inst_q;
    assign dbg_state = state_q;

    assign ar_fire = arvalid & arready;
    assign r_fire  = rready & rvalid;

    // Once arvalid is raised the address is frozen until accepted, even if
    // the PC is redirected meanwhile; otherwise it follows the next PC.
    assign ar_addr_d = arvalid ? ar_addr_q : pc_d;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        drop_d   = drop_q;
        load_out = 1'b0;
        unique case (state_q)
            REQ: begin
                if (ar_fire) begin
                    state_d = WAIT;
                end
                if (redirect) begin
                    pc_d = tgt;
                    // An issued AR must still complete; its data is dropped.
                    if (arvalid) begin
                        drop_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (r_fire) begin
                    state_d = REQ;
                    if (drop_q) begin
                        drop_d = 1'b0;
                    end else if (!redirect) begin
                        state_d  = HOLD;
                        load_out = 1'b1;
                    end
                    if (redirect) begin
                        pc_d = tgt;
                    end
                end else if (redirect) begin
                    pc_d   = tgt;
                    drop_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = tgt;
                    state_d = REQ;
                end else if (out_ready) begin
                    pc_d    = npc;
                    state_d = REQ;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= REQ;
            pc_q       <= RESET_PC;
            drop_q     <= 1'b0;
            ar_addr_q  <= RESET_PC;
            started_q  <= 1'b0;
            out_pc_q   <= 32'd0;
            out_inst_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            drop_q    <= drop_d;
            ar_addr_q <= ar_addr_d;
            started_q <= 1'b1;
            if (load_out) begin
                out_pc_q   <= pc_q;
                out_inst_q <= rdata;
            end
        end
    end

`ifdef YSYX_23060203_IFU_FAULT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else if (load_out) begin
            fault_q <= (rresp != RESP_OKAY);
        end
    end
`endif

endmodule
